// File: rtl/rr_mux4_arbiter8_pkg.sv
// Shared types, constants and the round-robin pick function for the
// four-source bursting arbiter.
package rr_mux4_arbiter8_pkg;

    localparam int NREQ              = 4;
    localparam int DEFAULT_MAX_BURST = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Scan ptr+1, ptr+2, ptr+3, ptr (mod 4), optionally skipping mask_idx.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req,
                                      input logic [1:0]      ptr,
                                      input logic [1:0]      mask_idx,
                                      input logic            mask_en);
        pick_t      pick;
        logic [1:0] cand;
        pick = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = ptr + 2'(i);
            if (!pick.found && req[cand] && !(mask_en && (cand == mask_idx))) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux4to18bit.sv
// 8-bit 4:1 multiplexer; sel 0..3 selects d1..d4.
module mux4to18bit (
    input  logic [7:0] d1,
    input  logic [7:0] d2,
    input  logic [7:0] d3,
    input  logic [7:0] d4,
    input  logic [1:0] sel,
    output logic [7:0] out
);

    always_comb begin
        case (sel)
            2'd0:    out = d1;
            2'd1:    out = d2;
            2'd2:    out = d3;
            default: out = d4;
        endcase
    end

endmodule

// File: rtl/rr_mux4_arbiter8.sv
// Round-robin arbiter granting bursts of up to MAX_BURST beats to one of four
// 8-bit sources and steering that source onto a single valid-gated bus.
module rr_mux4_arbiter8
    import rr_mux4_arbiter8_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [7:0] d1,
    input  logic [7:0] d2,
    input  logic [7:0] d3,
    input  logic [7:0] d4,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       busy
);

    localparam int              CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       mux_out;
    logic             owner_req;
    logic             release_now;
    pick_t            pick;

    assign owner_req = req[sel_q];
    // While owning, the current owner is masked so it gets lowest priority at handover.
    assign pick      = rr_pick(req, ptr_q, sel_q, state_q == OWN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick.found) begin
                    state_d = OWN;
                    sel_d   = pick.idx;
                    ptr_d   = pick.idx;
                    grant_d = 4'b0001 << pick.idx;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                release_now = !owner_req || (cnt_q == LAST_BEAT);
                if (!release_now) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (pick.found) begin
                    sel_d   = pick.idx;
                    ptr_d   = pick.idx;
                    grant_d = 4'b0001 << pick.idx;
                    cnt_d   = '0;
                end else if (owner_req) begin
                    cnt_d = '0;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mux4to18bit u_mux (
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .d4  (d4),
        .sel (sel_q),
        .out (mux_out)
    );

    always_comb begin
        busy      = (state_q == OWN);
        out_valid = busy && owner_req;
        out       = out_valid ? mux_out : 8'h00;
        grant     = grant_q;
        sel       = sel_q;
    end

    grant_onehot_a: assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant_q) && ((state_q != OWN) || grant_q[sel_q]));

endmodule

// File: tb/tb_rr_mux4_arbiter8.sv
// Self-checking bench: two arbiters (MAX_BURST 4 and 1) on shared inputs,
// compared every cycle against a behavioural round-robin burst model.
module tb_rr_mux4_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] d1, d2, d3, d4;

    logic [3:0] a_grant, b_grant;
    logic [1:0] a_sel, b_sel;
    logic [7:0] a_out, b_out;
    logic       a_valid, b_valid, a_busy, b_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    int mb      [2] = '{4, 1};
    int m_owner [2];
    int m_last  [2];
    int m_beats [2];
    int m_sel   [2];

    rr_mux4_arbiter8 #(.MAX_BURST(4)) dut4 (
        .clk(clk), .rst(rst), .req(req),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .grant(a_grant), .sel(a_sel), .out(a_out),
        .out_valid(a_valid), .busy(a_busy)
    );

    rr_mux4_arbiter8 #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .grant(b_grant), .sel(b_sel), .out(b_out),
        .out_valid(b_valid), .busy(b_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dataOf(int i);
        case (i)
            0:       return d1;
            1:       return d2;
            2:       return d3;
            default: return d4;
        endcase
    endfunction

    // First requester after the last granted one, skipping 'exclude'.
    function automatic int pickNext(int k, int exclude);
        for (int s = 1; s <= 4; s++) begin
            int c;
            c = (m_last[k] + s) % 4;
            if (req[c] && c != exclude) return c;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_last[k]  = 3;
            m_beats[k] = 0;
            m_sel[k]   = 0;
        end
    endtask

    task automatic grantTo(int k, int w);
        m_owner[k] = w;
        m_last[k]  = w;
        m_sel[k]   = w;
        m_beats[k] = 0;
    endtask

    task automatic modelAdvance();
        for (int k = 0; k < 2; k++) begin
            int o;
            int w;
            bit rel;
            o = m_owner[k];
            if (o < 0) begin
                w = pickNext(k, -1);
                if (w >= 0) grantTo(k, w);
            end else begin
                rel = 1'b0;
                if (req[o]) begin
                    m_beats[k]++;
                    if (m_beats[k] == mb[k]) rel = 1'b1;
                end else begin
                    rel = 1'b1;
                end
                if (rel) begin
                    w = pickNext(k, o);
                    if (w >= 0)      grantTo(k, w);
                    else if (req[o]) m_beats[k] = 0;
                    else             m_owner[k] = -1;
                end
            end
        end
    endtask

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        for (int k = 0; k < 2; k++) begin
            int         o;
            logic [3:0] g_e;
            logic       v_e;
            logic [7:0] out_e;
            o     = m_owner[k];
            g_e   = (o >= 0) ? 4'(1 << o) : 4'b0000;
            v_e   = (o >= 0) ? req[o] : 1'b0;
            out_e = v_e ? dataOf(o) : 8'h00;
            if (k == 0) begin
                check("mb4.grant", 8'(a_grant), 8'(g_e));
                check("mb4.sel",   8'(a_sel),   8'(m_sel[k]));
                check("mb4.valid", 8'(a_valid), 8'(v_e));
                check("mb4.out",   a_out,       out_e);
                check("mb4.busy",  8'(a_busy),  8'(o >= 0));
            end else begin
                check("mb1.grant", 8'(b_grant), 8'(g_e));
                check("mb1.sel",   8'(b_sel),   8'(m_sel[k]));
                check("mb1.valid", 8'(b_valid), 8'(v_e));
                check("mb1.out",   b_out,       out_e);
                check("mb1.busy",  8'(b_busy),  8'(o >= 0));
            end
        end
    endtask

    task automatic applyStimulus(logic [3:0] r, logic [7:0] a, logic [7:0] b,
                                 logic [7:0] c, logic [7:0] d);
        req = r;
        d1  = a;
        d2  = b;
        d3  = c;
        d4  = d;
    endtask

    // Check at the falling edge, then let the model absorb the edge.
    task automatic runCycles(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput();
            if (rst) modelReset();
            else     modelAdvance();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        #2;
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(4'b0000, 8'h11, 8'h22, 8'h33, 8'h44);
        modelReset();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] idle with no requests");
        runCycles(10);

        $display("[TB] single requester, continuous re-grant");
        applyStimulus(4'b0001, 8'h11, 8'h22, 8'h33, 8'h44);
        runCycles(10);

        $display("[TB] all requesting, bursts rotate");
        applyStimulus(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
        runCycles(20);

        $display("[TB] owner drops mid-burst");
        doReset();
        applyStimulus(4'b0100, 8'h11, 8'h22, 8'h33, 8'h44);
        runCycles(1);
        applyStimulus(4'b0101, 8'h11, 8'h22, 8'h33, 8'h44);
        runCycles(2);
        applyStimulus(4'b0001, 8'h11, 8'h22, 8'h33, 8'h44);
        runCycles(1);
        check("drop.grant", 8'(a_grant), 8'h01);
        check("drop.sel",   8'(a_sel),   8'h00);
        runCycles(3);

        $display("[TB] beat-level alternation");
        doReset();
        applyStimulus(4'b1000, 8'h11, 8'h22, 8'h33, 8'h44);
        runCycles(1);
        applyStimulus(4'b1001, 8'h11, 8'h22, 8'h33, 8'h44);
        runCycles(8);

        $display("[TB] asynchronous reset mid-burst");
        doReset();
        applyStimulus(4'b0010, 8'h11, 8'h22, 8'h33, 8'h44);
        runCycles(3);
        #2;
        rst = 1'b1;
        #1;
        check("arst.grant", 8'(a_grant), 8'h00);
        check("arst.sel",   8'(a_sel),   8'h00);
        check("arst.out",   a_out,       8'h00);
        check("arst.valid", 8'(a_valid), 8'h00);
        check("arst.busy",  8'(a_busy),  8'h00);
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'b0110, 8'h11, 8'h22, 8'h33, 8'h44);
        runCycles(1);
        check("arst.regrant", 8'(a_grant), 8'h02);
        runCycles(4);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = req;
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            applyStimulus(r, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 99) == 0) doReset();
            runCycles(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux4_arbiter8.md
Name: rr_mux4_arbiter8

Overview:
Round-robin arbiter that shares one 8-bit 4:1 multiplexed output bus between four requesters. It grants bursts of up to MAX_BURST beats to one requester at a time and drives the mux select from registered state. It gates the bus with a valid strobe. It sits in front of any single-consumer sink fed by four 8-bit sources.

Parameters:
MAX_BURST, 4, maximum beats per grant; legal range >= 1.
CNT_W, $clog2(MAX_BURST+1), width of the beat counter. Derived; do not override.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req  in  4  request per source; req[i] belongs to source i (d1 = source 0 … d4 = source 3).
d1  in  8  source 0 data.
d2  in  8  source 1 data.
d3  in  8  source 2 data.
d4  in  8  source 3 data.
grant  out  4  one-hot registered grant; 0 when no owner.
sel  out  2  registered mux select, equal to the owner index.
out  out  8  selected data when out_valid = 1, else 8'h00.
out_valid  out  1  a beat is transferred this cycle.
busy  out  1  state == OWN.

Behaviour:
- Reset values (asynchronous, immediate): state = IDLE, grant = 0, sel = 0, ptr = 3, cnt = 0, out_valid = 0, out = 0, busy = 0.
- ptr holds the last granted index. Priority search order is ptr+1, ptr+2, ptr+3, ptr (mod 4). The first set req in that order wins.
- IDLE:
  - If req != 0: register the winner into sel/grant, set ptr = winner, cnt = 0, go to OWN.
  - Otherwise stay in IDLE.
  - Latency: req asserted in cycle N gives grant in cycle N+1 and the first possible beat in N+1.
- OWN:
  - out_valid = req[sel] (combinational). out = mux(d1..d4, sel) when out_valid, else 0. Data passes through with zero cycles of latency.
  - A beat is a cycle with out_valid = 1; each beat increments cnt.
- Release occurs in either of two cycles:
  - A cycle where req[sel] = 0. This is not a beat.
  - The beat where cnt == MAX_BURST-1, i.e. the last beat of the burst.
- On release, re-arbitrate in the same cycle over req, with the current owner masked out:
  - If another request is pending, switch directly to the new winner next cycle (no bubble), with cnt = 0 and ptr = new winner.
  - If none is pending and the owner's req is still high (burst expiry only), re-grant the same owner with cnt = 0.
  - Otherwise clear grant and go to IDLE.
- The owner always gets lowest priority at handover. Any source with req held high is granted within 3 bursts (starvation bound).
- Changes of req[i] for non-owners during OWN have no effect until release.
- MAX_BURST = 1: every beat is a release, giving strict beat-level round robin.
- cnt never exceeds MAX_BURST-1 and never wraps.
- Reset asserted mid-burst: all outputs go to their reset values asynchronously. After deassertion, arbitration restarts with source 0 first.
- grant is always zero or one-hot, and grant[sel] == 1 whenever busy = 1 (assertion).

Decomposition:
- Shared package holds:
  - NREQ = 4.
  - State enum {IDLE, OWN}.
  - Default MAX_BURST.
  - A function rr_pick(req, ptr, mask_idx, mask_en) returning {found, idx}.
- Datapath sub-module: instantiate the team's existing 8-bit 4:1 mux, mux4to18bit (d1..d4, sel, out). The arbiter gates its output with out_valid.
- No other sub-modules.

Test Plan:
1. Reset, then req = 4'b0001 held, MAX_BURST = 4 → grant = 0001 from cycle 1; four beats with out = d1; re-grant of source 0 with no bubble; out_valid stays 1 continuously.
2. req = 4'b1111 held, d1..d4 = 8'h11/22/33/44 → bursts of 4 in order 0,1,2,3,0; out = 11×4, 22×4, 33×4, 44×4, 11…; no idle cycles.
3. Source 2 owns; at beat 2 req[2] drops while req[0] = 1 → that cycle out_valid = 0 and out = 0; next cycle grant = 0001, sel = 0.
4. Source 3 owns, MAX_BURST = 1, req = 4'b1001 → grants alternate 0,3,0,3 each cycle.
5. rst asserted mid-burst (source 1, beat 2) → grant, sel, out, out_valid and busy are 0 immediately; after release with req = 4'b0110, grant = 0010 (ptr reset to 3, so source 1 wins first).
6. req = 0 for 10 cycles after reset → state stays IDLE, out = 0, busy = 0 throughout.
